pgm_rcv: RTL



---
 rtl/pgm_rcv_if.sv | 18 +
 rtl/pgm_rcv.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pgm_rcv_if.sv
// Packet stream from the generator path into the receiver.
interface pgm_rcv_if;
   logic [133:0] in_rcv_data;
   logic         in_rcv_data_wr;
   logic         in_rcv_valid;
   logic         in_rcv_valid_wr;
   logic         out_rcv_alf;

   modport master (
      output in_rcv_data, in_rcv_data_wr, in_rcv_valid, in_rcv_valid_wr,
      input  out_rcv_alf
   );

   modport slave (
      input  in_rcv_data, in_rcv_data_wr, in_rcv_valid, in_rcv_valid_wr,
      output out_rcv_alf
   );
endinterface

// File: rtl/pgm_rcv.sv
// Receive-side sink for generated traffic: classifies generator packets,
// checks sequence numbers, measures one-way latency and keeps statistics.
//
//   state | meaning
//   IDLE  | between packets, expecting a head
//   BODY  | head seen, accumulating body/tail words
module pgm_rcv #(
   parameter logic [15:0] MAGIC = 16'h5047,
   parameter logic [7:0]  LMID  = 8'd7
) (
   input  logic        clk,
   input  logic        rst,
   pgm_rcv_if.slave    rcv,
   input  logic        in_rcv_clr,
   output logic [7:0]  out_rcv_mid,
   output logic [31:0] out_rcv_pkt_cnt,
   output logic [47:0] out_rcv_byte_cnt,
   output logic [15:0] out_rcv_drop_cnt,
   output logic [15:0] out_rcv_seq_err_cnt,
   output logic [15:0] out_rcv_frm_err_cnt,
   output logic [31:0] out_rcv_lat_last,
   output logic [31:0] out_rcv_lat_max
);

   typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

   localparam logic [1:0] CT_HEAD = 2'b01;
   localparam logic [1:0] CT_BODY = 2'b11;
   localparam logic [1:0] CT_TAIL = 2'b10;
   localparam logic [1:0] CT_NONE = 2'b00;

   state_t      state;
   logic [63:0] timer;
   logic        is_gen;
   logic [31:0] seq_cap;
   logic [31:0] lat_cap;
   logic [31:0] acc;
   logic [31:0] exp_seq;
   logic        exp_vld;

   logic [1:0]  cyc_type;
   logic [3:0]  inv_cnt;
   logic [63:0] lat_diff;
   logic [31:0] head_lat;
   logic [31:0] acc_tail;
   logic        wr;
   logic        frm_evt;
   logic        commit;
   logic        good;
   logic        unused_bits;

   assign rcv.out_rcv_alf = 1'b0;
   assign out_rcv_mid     = LMID;

   assign cyc_type = rcv.in_rcv_data[133:132];
   assign inv_cnt  = rcv.in_rcv_data[131:128];
   assign wr       = rcv.in_rcv_data_wr;
   assign good     = rcv.in_rcv_valid_wr & rcv.in_rcv_valid;

   // A timestamp in the future wraps to a huge difference and saturates too.
   assign lat_diff = timer - rcv.in_rcv_data[79:16];
   assign head_lat = (|lat_diff[63:32]) ? 32'hFFFF_FFFF : lat_diff[31:0];
   assign acc_tail = acc + 32'd16 - {28'd0, inv_cnt};

   assign frm_evt = wr & ((cyc_type == CT_NONE) ||
                          (state == IDLE && (cyc_type == CT_BODY || cyc_type == CT_TAIL)) ||
                          (state == BODY && cyc_type == CT_HEAD));
   assign commit  = wr & (state == BODY) & (cyc_type == CT_TAIL) & is_gen;

   assign unused_bits = ^rcv.in_rcv_data[15:0];

   // Free-running latency reference; only reset touches it.
   always_ff @(posedge clk) begin
      if (rst) timer <= '0;
      else     timer <= timer + 64'd1;
   end

   // Packet framing FSM, head capture and statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         is_gen              <= 1'b0;
         seq_cap             <= '0;
         lat_cap             <= '0;
         acc                 <= '0;
         exp_seq             <= '0;
         exp_vld             <= 1'b0;
         out_rcv_pkt_cnt     <= '0;
         out_rcv_byte_cnt    <= '0;
         out_rcv_drop_cnt    <= '0;
         out_rcv_seq_err_cnt <= '0;
         out_rcv_frm_err_cnt <= '0;
         out_rcv_lat_last    <= '0;
         out_rcv_lat_max     <= '0;
      end else begin
         // Clear takes priority over any statistic update in the same cycle.
         if (in_rcv_clr) begin
            exp_vld             <= 1'b0;
            out_rcv_pkt_cnt     <= '0;
            out_rcv_byte_cnt    <= '0;
            out_rcv_drop_cnt    <= '0;
            out_rcv_seq_err_cnt <= '0;
            out_rcv_frm_err_cnt <= '0;
            out_rcv_lat_last    <= '0;
            out_rcv_lat_max     <= '0;
         end else begin
            if (frm_evt && out_rcv_frm_err_cnt != 16'hFFFF)
               out_rcv_frm_err_cnt <= out_rcv_frm_err_cnt + 16'd1;
            if (commit) begin
               if (!good) begin
                  if (out_rcv_drop_cnt != 16'hFFFF)
                     out_rcv_drop_cnt <= out_rcv_drop_cnt + 16'd1;
               end else begin
                  out_rcv_pkt_cnt  <= out_rcv_pkt_cnt + 32'd1;
                  out_rcv_byte_cnt <= out_rcv_byte_cnt + {16'd0, acc_tail};
                  out_rcv_lat_last <= lat_cap;
                  if (lat_cap > out_rcv_lat_max)
                     out_rcv_lat_max <= lat_cap;
                  if (exp_vld && seq_cap != exp_seq && out_rcv_seq_err_cnt != 16'hFFFF)
                     out_rcv_seq_err_cnt <= out_rcv_seq_err_cnt + 16'd1;
                  exp_seq <= seq_cap + 32'd1;
                  exp_vld <= 1'b1;
               end
            end
         end

         // A head always restarts capture, discarding any packet in flight.
         if (wr) begin
            case (cyc_type)
               CT_HEAD: begin
                  is_gen  <= (rcv.in_rcv_data[127:112] == MAGIC);
                  seq_cap <= rcv.in_rcv_data[111:80];
                  lat_cap <= head_lat;
                  acc     <= 32'd16;
                  state   <= BODY;
               end
               CT_BODY: begin
                  if (state == BODY) acc <= acc + 32'd16;
               end
               CT_TAIL: begin
                  if (state == BODY) state <= IDLE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
